// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg -- shared constants for the FIR output formatting path.
//   FIR_*           : default widths, shift, decimation and buffer depth
//   FIR_PIPE_STAGES : edges from sample acceptance to FIFO write
//   fifo_op_e       : per-edge FIFO operation (push/pop combination)
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_IN_WIDTH    = 33;
  localparam int FIR_OUT_WIDTH   = 16;
  localparam int FIR_SHIFT       = 17;
  localparam int FIR_DECIM       = 4;
  localparam int FIR_FIFO_DEPTH  = 8;

  // Round stage + shift/saturate stage.
  localparam int FIR_PIPE_STAGES = 2;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock show-ahead FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count)
//   wr_en      : write request; wr_data is the entry
//   rd_ready   : consumer accepts rd_data (ignored while empty)
//   rd_data    : head entry, forced to 0 while empty
//   rd_valid   : FIFO not empty
//   count      : occupancy 0..DEPTH
//   wr_drop    : pulse, a write was lost because the FIFO was full
// ---------------------------------------------------------------------------
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_OUT_WIDTH,
  parameter int DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             rd;
  logic             wr;
  fifo_op_e         op;

  assign rd_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign rd       = rd_ready && rd_valid;
  // A pop on the same edge frees the slot a full-FIFO write needs.
  assign wr       = wr_en && (!full || rd);
  assign wr_drop  = wr_en && full && !rd;
  assign op       = fifo_op_e'({wr, rd});
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case (op)
        FIFO_PUSH: count <= count + 1'b1;
        FIFO_POP:  count <= count - 1'b1;
        default:   count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// ---------------------------------------------------------------------------
// fir_decim_out -- decimate, round, saturate and buffer FIR results.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   fir_in/in_en  : unsigned FIR result and its strobe
//   out_data/out_valid/out_ready : show-ahead output handshake
//   fifo_cnt      : buffer occupancy
//   ovf, sat      : sticky drop / clip flags, cleared by clr_flags
// ---------------------------------------------------------------------------
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_IN_WIDTH,
  parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
  parameter int SHIFT      = FIR_SHIFT,
  parameter int DECIM      = FIR_DECIM,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                          sclk,
  input  logic                          s_rst_n,
  input  logic [IN_WIDTH-1:0]           fir_in,
  input  logic                          in_en,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf,
  output logic                          sat,
  input  logic                          clr_flags
);

  localparam int                PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(DECIM - 1);
  localparam int                SUM_W   = IN_WIDTH + 1;
  localparam logic [SUM_W-1:0]  RND     = SUM_W'(1) << (SHIFT - 1);
  localparam logic [SUM_W-1:0]  SAT_MAX = SUM_W'({OUT_WIDTH{1'b1}});

  // Extra MSB keeps the rounding add from wrapping near full scale.
  function automatic logic [SUM_W-1:0] round_half_up(input logic [IN_WIDTH-1:0] x);
    return {1'b0, x} + RND;
  endfunction

  function automatic logic sat_hit(input logic [SUM_W-1:0] v);
    return (v >> SHIFT) > SAT_MAX;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_clip(input logic [SUM_W-1:0] v);
    logic [SUM_W-1:0] sh;
    sh = v >> SHIFT;
    return (sh > SAT_MAX) ? {OUT_WIDTH{1'b1}} : sh[OUT_WIDTH-1:0];
  endfunction

  logic [PH_W-1:0]      phase;
  logic                 accept;
  logic [SUM_W-1:0]     sum_p1;
  logic                 vld_p1;
  logic [OUT_WIDTH-1:0] data_p2;
  logic                 vld_p2;
  logic                 sat_evt;
  logic                 fifo_drop;

  assign accept  = in_en && (phase == '0);
  assign sat_evt = vld_p1 && sat_hit(sum_p1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      phase <= '0;
    end else if (in_en) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Stage 1: round-half-up
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) sum_p1 <= round_half_up(fir_in);
    end
  end

  // Stage 2: shift and saturate
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      data_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= sat_clip(sum_p1);
    end
  end

  // Sticky flags: a new event on the clearing edge keeps the flag set.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sat <= sat_evt   || (sat && !clr_flags);
      ovf <= fifo_drop || (ovf && !clr_flags);
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sclk),
    .rst_n    (s_rst_n),
    .wr_en    (vld_p2),
    .wr_data  (data_p2),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_cnt),
    .wr_drop  (fifo_drop)
  );

endmodule
